// File: rtl/fnd_pkg.sv
// Shared FND definitions: active-low segment patterns, scan FSM states and the blank digit code.
package fnd_pkg;

    // Segment patterns on data[6:0] (g..a), active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } scan_state_t;

    function automatic logic sel_valid(input logic [3:0] digit);
        case (digit)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: sel_valid = 1'b1;
            default:                            sel_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] digit);
        case (digit)
            4'b1101: sel_index = 2'd1;
            4'b1011: sel_index = 2'd2;
            4'b0111: sel_index = 2'd3;
            default: sel_index = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// FND bus as seen by the loopback decoder, plus the rebuilt frame outputs.
interface fnd_scan_decoder_if;
    logic [3:0]  fnd_digit;
    logic [7:0]  fnd_data;
    logic [15:0] o_bcd;
    logic [3:0]  o_dp;
    logic        o_frame_valid;
    logic        o_seg_err;
    logic        o_stale;

    modport master (
        output fnd_digit, fnd_data,
        input  o_bcd, o_dp, o_frame_valid, o_seg_err, o_stale
    );

    modport slave (
        input  fnd_digit, fnd_data,
        output o_bcd, o_dp, o_frame_valid, o_seg_err, o_stale
    );
endinterface

// File: rtl/seg7_to_bcd.sv
// Active-low 7-segment pattern to digit code; unknown patterns give blank plus err.
// Latency: combinational.
// Backpressure: none.
module seg7_to_bcd
    import fnd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = BCD_BLANK;
        err = 1'b0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BCD_BLANK;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Rebuilds the four displayed digits from the multiplexed active-low FND bus.
// Latency: capture SETTLE cycles after pins go stable, frame outputs one cycle after the 4th capture.
// Backpressure: none; the display bus cannot be stalled, only observed.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 200_000
) (
    input  logic             clk,
    input  logic             reset,
    fnd_scan_decoder_if.slave bus
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [3:0]  r_digit, p_digit;
    logic [7:0]  r_data, p_data;

    scan_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [TW-1:0] stale_cnt;

    logic        capture;
    logic        changed;
    logic        sel_ok;
    logic [1:0]  sel_k;
    logic [3:0]  dec_bcd;
    logic        dec_err;

    logic [15:0] slot_bcd, frame_bcd, o_bcd_q;
    logic [3:0]  slot_dp, frame_dp, o_dp_q;
    logic [3:0]  slot_err, frame_err;
    logic [3:0]  mask, mask_nxt;
    logic        frame_done;
    logic        frame_valid_q, seg_err_q;

    // p_* is one cycle behind r_*, so any difference means the bus moved
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit <= 4'hF;
            r_data  <= 8'hFF;
            p_digit <= 4'hF;
            p_data  <= 8'hFF;
        end else begin
            r_digit <= bus.fnd_digit;
            r_data  <= bus.fnd_data;
            p_digit <= r_digit;
            p_data  <= r_data;
        end
    end

    assign changed = (r_digit != p_digit) || (r_data != p_data);
    assign sel_ok  = sel_valid(r_digit);
    assign sel_k   = sel_index(r_digit);

    seg7_to_bcd u_seg7_to_bcd (
        .seg (r_data[6:0]),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= fnd_pkg::IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The cycle that sees a change already counts as stable cycle 0, hence the restart value of 1
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        if (!sel_ok) begin
            state_nxt = fnd_pkg::IDLE;
            cnt_nxt   = '0;
        end else if (changed) begin
            state_nxt = fnd_pkg::SETTLE;
            cnt_nxt   = CW'(1);
        end else begin
            case (state)
                fnd_pkg::SETTLE: begin
                    if (cnt >= CW'(SETTLE - 1)) begin
                        capture   = 1'b1;
                        state_nxt = fnd_pkg::HOLD;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                fnd_pkg::HOLD: state_nxt = fnd_pkg::HOLD;
                default: begin
                    state_nxt = fnd_pkg::SETTLE;
                    cnt_nxt   = CW'(1);
                end
            endcase
        end
    end

    always_comb begin
        frame_bcd = slot_bcd;
        frame_dp  = slot_dp;
        frame_err = slot_err;
        mask_nxt  = mask;
        if (capture) begin
            frame_bcd[{sel_k, 2'b00} +: 4] = dec_bcd;
            frame_dp[sel_k]                = ~r_data[7];
            frame_err[sel_k]               = dec_err;
            mask_nxt[sel_k]                = 1'b1;
        end
    end

    assign frame_done = capture && (mask_nxt == 4'hF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_bcd      <= 16'hFFFF;
            slot_dp       <= '0;
            slot_err      <= '0;
            mask          <= '0;
            o_bcd_q       <= 16'hFFFF;
            o_dp_q        <= '0;
            seg_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= frame_done;
            if (capture) begin
                slot_bcd <= frame_bcd;
                slot_dp  <= frame_dp;
                mask     <= frame_done ? 4'h0 : mask_nxt;
                slot_err <= frame_done ? 4'h0 : frame_err;
            end
            if (frame_done) begin
                o_bcd_q   <= frame_bcd;
                o_dp_q    <= frame_dp;
                seg_err_q <= |frame_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stale_cnt <= '0;
        end else if (capture) begin
            stale_cnt <= '0;
        end else if (stale_cnt != TW'(TIMEOUT)) begin
            stale_cnt <= stale_cnt + TW'(1);
        end
    end

    assign bus.o_bcd         = o_bcd_q;
    assign bus.o_dp          = o_dp_q;
    assign bus.o_frame_valid = frame_valid_q;
    assign bus.o_seg_err     = seg_err_q;
    assign bus.o_stale       = (stale_cnt == TW'(TIMEOUT));

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Loopback bench for fnd_scan_decoder: scanned digits in, expected frames checked from a scoreboard.
module tb_fnd_scan_decoder;
    import fnd_pkg::*;

    localparam int SET = 16;
    localparam int TMO = 300;
    localparam int WIN = 40;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic fv_prev = 1'b0;
    exp_t sb[$];

    fnd_scan_decoder_if bus ();

    fnd_scan_decoder #(.SETTLE(SET), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic [7:0] dat, input int n);
        logic [3:0] sel;
        sel = 4'b0001 << idx;
        bus.fnd_digit = ~sel;
        bus.fnd_data  = dat;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.fnd_digit = 4'hF;
        bus.fnd_data  = 8'hFF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just before the frame-completing digit is driven: pins change this cycle,
    // capture lands SET cycles later and the pulse one cycle after that.
    task automatic expect_frame(input logic [15:0] bcd, input logic [3:0] dp, input logic err);
        exp_t e;
        e.bcd = bcd;
        e.dp  = dp;
        e.err = err;
        e.cyc = cyc + SET + 1;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            fv_prev = 1'b0;
        end else begin
            if (bus.o_frame_valid) begin
                chk("fv_single_pulse", {31'd0, fv_prev}, 32'd0);
                chk("frame_expected", {31'd0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("frame_bcd", {16'd0, bus.o_bcd}, {16'd0, e.bcd});
                    chk("frame_dp", {28'd0, bus.o_dp}, {28'd0, e.dp});
                    chk("frame_err", {31'd0, bus.o_seg_err}, {31'd0, e.err});
                    chk("frame_cycle", cyc, e.cyc);
                end
            end
            fv_prev = bus.o_frame_valid;
        end
    end

    initial begin
        reset         = 1'b0;
        bus.fnd_digit = 4'hF;
        bus.fnd_data  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", {16'd0, bus.o_bcd}, 32'h0000FFFF);
        chk("rst_dp", {28'd0, bus.o_dp}, 32'd0);
        chk("rst_fv", {31'd0, bus.o_frame_valid}, 32'd0);
        chk("rst_err", {31'd0, bus.o_seg_err}, 32'd0);
        chk("rst_stale", {31'd0, bus.o_stale}, 32'd0);
        reset = 1'b1;
        idle(5);

        // Normal scan, long windows
        drive(3, 8'hC0, 1000);
        drive(2, 8'hF9, 1000);
        drive(1, 8'hA4, 1000);
        expect_frame(16'h0123, 4'b0000, 1'b0);
        drive(0, 8'hB0, 1000);

        // Decimal point and blank
        drive(3, 8'hFF, WIN);
        drive(2, 8'h12, WIN);
        drive(1, 8'hA4, WIN);
        expect_frame(16'hF523, 4'b0100, 1'b0);
        drive(0, 8'hB0, WIN);

        // Short glitch on digit 1 must not be captured
        drive(3, 8'hC0, WIN);
        drive(2, 8'hF9, WIN);
        drive(1, 8'hF9, 30);
        drive(1, 8'h80, 10);
        drive(1, 8'hF9, 30);
        expect_frame(16'h0113, 4'b0000, 1'b0);
        drive(0, 8'hB0, WIN);

        // Undecodable pattern, then a clean frame clears the error
        drive(3, 8'hC0, WIN);
        drive(2, 8'hF9, WIN);
        drive(1, 8'hA4, WIN);
        expect_frame(16'h012F, 4'b0000, 1'b1);
        drive(0, 8'hAA, WIN);
        drive(3, 8'hC0, WIN);
        drive(2, 8'hF9, WIN);
        drive(1, 8'hA4, WIN);
        expect_frame(16'h0123, 4'b0000, 1'b0);
        drive(0, 8'hB0, WIN);

        // Stale with no valid select, then recovery
        chk("stale_before", {31'd0, bus.o_stale}, 32'd0);
        idle(TMO + 5);
        chk("stale_set", {31'd0, bus.o_stale}, 32'd1);
        drive(3, 8'h99, WIN);
        chk("stale_cleared", {31'd0, bus.o_stale}, 32'd0);
        drive(2, 8'h92, WIN);
        drive(1, 8'h82, WIN);
        expect_frame(16'h4567, 4'b0000, 1'b0);
        drive(0, 8'hF8, WIN);

        // Async reset after two captures discards them
        drive(3, 8'h80, WIN);
        drive(2, 8'h90, WIN);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_bcd", {16'd0, bus.o_bcd}, 32'h0000FFFF);
        chk("arst_dp", {28'd0, bus.o_dp}, 32'd0);
        chk("arst_fv", {31'd0, bus.o_frame_valid}, 32'd0);
        chk("arst_err", {31'd0, bus.o_seg_err}, 32'd0);
        chk("arst_stale", {31'd0, bus.o_stale}, 32'd0);
        bus.fnd_digit = 4'hF;
        bus.fnd_data  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(5);
        drive(1, 8'hC0, WIN);
        drive(0, 8'hF9, WIN);
        drive(3, 8'hA4, WIN);
        expect_frame(16'h2301, 4'b0000, 1'b0);
        drive(2, 8'hB0, WIN);

        idle(20);
        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_scan_decoder.md
# fnd_scan_decoder

Receiving end of the multiplexed 7-segment (FND) bus. The block samples the active-low `fnd_digit` / `fnd_data` lines driven by the FND controller and rebuilds the four displayed digits, decimal points and a frame-valid pulse. It sits beside the FND controller in loopback, so the bench and on-chip self-checks can read back what the display actually shows.

## Interface
- `SETTLE`, 16: cycles that `fnd_digit` and `fnd_data` must both hold steady before a digit is captured (1..255).
- `TIMEOUT`, 200_000: cycles without any capture before `o_stale` asserts (2 ms at 100 MHz).
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: asynchronous, active-low reset.
- `fnd_digit` input 4: digit select, active-low one-hot; bit k low means digit k (0 = rightmost) is lit.
- `fnd_data` input 8: segments, active-low; [6:0] = g..a, [7] = dp.
- `o_bcd` output 16: captured digits, [3:0] = digit 0 … [15:12] = digit 3; 4'hF = blank.
- `o_dp` output 4: decimal point per digit, 1 = lit.
- `o_frame_valid` output 1: one-cycle pulse when `o_bcd`/`o_dp`/`o_seg_err` update.
- `o_seg_err` output 1: the frame just reported contained an undecodable segment pattern.
- `o_stale` output 1: no capture for `TIMEOUT` cycles.

## Operation
- Input stage: `fnd_digit` and `fnd_data` are registered once. All decisions use the registered copies (`r_digit`, `r_data`).
- Segment decode uses `r_data[6:0]`:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 7F→F (blank).
  - Any other pattern decodes to F and sets the per-digit error flag.
  - dp = ~`r_data[7]`.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: `r_digit` is not one-hot-low (4'hF or multi-low). Leave IDLE → SETTLE when a valid one-hot-low select appears; clear the settle counter.
  - SETTLE: the counter increments each cycle.
    - Any change of `r_digit` or `r_data` restarts the counter. An invalid select goes to IDLE.
    - At count == `SETTLE-1`, capture: write the digit value, dp and error flag into slot k, set mask bit k, go to HOLD.
  - HOLD: wait. A change of `r_digit` goes to SETTLE (valid select) or IDLE (invalid). A change of `r_data` only, with the same select, goes to SETTLE so the new value is recaptured for digit k.
- Frame assembly:
  - The 4-bit capture mask tracks digits seen since the last frame.
  - Recapturing a slot before the frame completes overwrites it.
  - When a capture makes the mask 4'hF: copy all slots to `o_bcd`/`o_dp`, set `o_seg_err` = OR of the four slot error flags, pulse `o_frame_valid`, clear the mask and slot error flags.
- Stale counter: reset on every capture, saturates at `TIMEOUT`. `o_stale` = (count == `TIMEOUT`). It clears on the cycle after the next capture.

## Timing
- Reset values: `o_bcd` = 16'hFFFF, `o_dp` = 0, `o_frame_valid` = 0, `o_seg_err` = 0, `o_stale` = 0. FSM = IDLE, mask = 0, counters = 0.
- Reset mid-frame discards partial captures. The first frame after reset needs all four digits.
- Capture latency: select and data stable at the pins from cycle t means capture at the end of cycle t+`SETTLE` (1 input register + `SETTLE` counting cycles).
- `o_frame_valid` rises the cycle after the completing capture, together with the new `o_bcd`/`o_dp`/`o_seg_err`. Outputs hold until the next frame.
- Simultaneous select change and counter terminal: the change wins, and no capture occurs.
- Glitches shorter than `SETTLE` cycles never produce a capture.
- Counter widths: `$clog2(SETTLE)`, `$clog2(TIMEOUT+1)`.

## Structure
- Shared package `fnd_pkg`:
  - Segment pattern constants `SEG_0`…`SEG_9`, `SEG_BLANK` (also used by the FND controller).
  - FSM state enum `scan_state_t` {IDLE, SETTLE, HOLD}.
  - `BCD_BLANK` = 4'hF.
- One sub-module `seg7_to_bcd`: combinational, takes 7 bits in and returns a 4-bit value plus an error flag. The top module holds the FSM, counters, slots and frame logic.

## Test plan
- Normal scan: drive digits 3..0 with C0,F9,A4,B0, 1000 cycles each, with `SETTLE`=16. After the 4th capture, one `o_frame_valid` pulse with `o_bcd` = 16'h0123, `o_dp` = 0, `o_seg_err` = 0.
- DP and blank: digit 2 = 8'h12 (5 with dp), digit 3 = 8'hFF. The frame gives `o_bcd[15:8]` = 8'hF5, `o_dp` = 4'b0100.
- Glitch rejection: insert a 10-cycle pattern 8'h80 on digit 1 between stable 8'hF9 windows. The frame reports 1 for digit 1, not 8.
- Bad pattern: digit 0 = 8'hAA. The frame gives `o_bcd[3:0]` = F and `o_seg_err` = 1. The next clean frame gives `o_seg_err` = 0.
- Stale and invalid select: hold `fnd_digit` = 4'hF for `TIMEOUT`+5 cycles. `o_stale` goes 1 and no frame occurs. Resume scanning: `o_stale` drops after the first capture.
- Async reset mid-frame: assert `reset` low after 2 captures. Outputs return to reset values immediately. The next frame appears only after 4 fresh captures.
